// File: rtl/adxl362_spi_slave.sv
// SPI mode-0 target emulating the ADXL362 register interface: 0x0A write, 0x0B read,
// auto-incrementing address pointer, per-frame shadowed acceleration samples.
module adxl362_spi_slave #(
  parameter logic [7:0] DEVID_AD = 8'hAD,
  parameter logic [7:0] PARTID   = 8'hF2
) (
  input  logic               iclk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs,
  input  logic               mosi,
  output logic               miso,
  input  logic signed [11:0] x_in,
  input  logic signed [11:0] y_in,
  input  logic signed [11:0] z_in,
  output logic [7:0]         power_ctl,
  output logic               measure_on,
  output logic               reg_wr,
  output logic               frame_done
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;
  localparam logic [7:0] A_PWR  = 8'h2D;

  state_t      state, state_n;
  logic [1:0]  sclk_sy, cs_sy, mosi_sy;
  logic        sclk_q, cs_q;
  logic        sclk_s, cs_s, mosi_s;
  logic        rise, fall, cs_fall, cs_rise, byte_done;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sh, rx_byte, tx_sh, addr, addr_sel, rd_data;
  logic        is_read;
  logic [11:0] x_sh, y_sh, z_sh;

  assign sclk_s    = sclk_sy[1];
  assign cs_s      = cs_sy[1];
  assign mosi_s    = mosi_sy[1];
  assign rise      = sclk_s & ~sclk_q;
  assign fall      = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sh[6:0], mosi_s};

  assign measure_on = (power_ctl[1:0] == 2'b10);
  assign miso       = (!cs_s && state == DATA && is_read) ? tx_sh[7] : 1'b0;

  // The first read byte is addressed by the byte still being assembled in ADDR.
  assign addr_sel = (state == ADDR) ? rx_byte : addr;

  always_comb begin
    rd_data = 8'h00;
    case (addr_sel)
      8'h00: rd_data = DEVID_AD;
      8'h01: rd_data = 8'h1D;
      8'h02: rd_data = PARTID;
      8'h03: rd_data = 8'h01;
      8'h08: rd_data = x_sh[11:4];
      8'h09: rd_data = y_sh[11:4];
      8'h0A: rd_data = z_sh[11:4];
      8'h0E: rd_data = x_sh[7:0];
      8'h0F: rd_data = {{4{x_sh[11]}}, x_sh[11:8]};
      8'h10: rd_data = y_sh[7:0];
      8'h11: rd_data = {{4{y_sh[11]}}, y_sh[11:8]};
      8'h12: rd_data = z_sh[7:0];
      8'h13: rd_data = {{4{z_sh[11]}}, z_sh[11:8]};
      A_PWR: rd_data = power_ctl;
      default: rd_data = 8'h00;
    endcase
    if (!measure_on && addr_sel >= 8'h08 && addr_sel <= 8'h13) rd_data = 8'h00;
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_rise) state_n = IDLE;
    else begin
      case (state)
        IDLE: if (cs_fall) state_n = CMD;
        CMD:  if (byte_done) state_n = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ADDR : IGNORE;
        ADDR: if (byte_done) state_n = DATA;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      sclk_sy    <= 2'b00;
      cs_sy      <= 2'b11;
      mosi_sy    <= 2'b00;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      bit_cnt    <= 3'd0;
      rx_sh      <= 8'h00;
      tx_sh      <= 8'h00;
      addr       <= 8'h00;
      is_read    <= 1'b0;
      x_sh       <= 12'h000;
      y_sh       <= 12'h000;
      z_sh       <= 12'h000;
      power_ctl  <= 8'h00;
      reg_wr     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sclk_sy    <= {sclk_sy[0], sclk};
      cs_sy      <= {cs_sy[0], cs};
      mosi_sy    <= {mosi_sy[0], mosi};
      sclk_q     <= sclk_s;
      cs_q       <= cs_s;
      reg_wr     <= 1'b0;
      frame_done <= 1'b0;
      if (cs_rise) begin
        // cs wins over a byte completing in the same cycle: nothing commits.
        bit_cnt <= 3'd0;
        if (state != IDLE) frame_done <= 1'b1;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            bit_cnt <= 3'd0;
            is_read <= 1'b0;
            x_sh    <= x_in;
            y_sh    <= y_in;
            z_sh    <= z_in;
          end
          CMD: if (rise) begin
            rx_sh   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) is_read <= (rx_byte == CMD_RD);
          end
          ADDR: if (rise) begin
            rx_sh   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
              if (is_read) begin
                tx_sh <= rd_data;
                addr  <= rx_byte + 8'd1;
              end else begin
                addr  <= rx_byte;
              end
            end
          end
          DATA: if (rise) begin
            rx_sh   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
              addr <= addr + 8'd1;
              if (is_read) tx_sh <= rd_data;
              else begin
                reg_wr <= 1'b1;
                if (addr == A_PWR) power_ctl <= rx_byte;
              end
            end
          end else if (fall && is_read && bit_cnt != 3'd0) begin
            // The fall right after a reload leaves bit 7 on the wire.
            tx_sh <= {tx_sh[6:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// Bench for adxl362_spi_slave: bit-banged SPI master, expected read bytes queued
// per frame and compared against the bytes captured on miso.
module tb_adxl362_spi_slave;

  logic              iclk = 1'b0;
  logic              rst;
  logic              sclk, cs, mosi;
  logic              miso;
  logic signed [11:0] x_in, y_in, z_in;
  logic [7:0]        power_ctl;
  logic              measure_on, reg_wr, frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  adxl362_spi_slave dut (
    .iclk(iclk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .power_ctl(power_ctl),
    .measure_on(measure_on), .reg_wr(reg_wr), .frame_done(frame_done)
  );

  always #5 iclk = ~iclk;

  always @(negedge iclk) begin
    if (reg_wr)     wr_cnt++;
    if (frame_done) fd_cnt++;
  end

  // Shift nbits of mo MSB first; miso is sampled just before each rising edge.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      repeat (8) @(negedge iclk);
      mi[i] = miso;
      sclk = 1'b1;
      repeat (8) @(negedge iclk);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    repeat (8) @(negedge iclk);
  endtask

  task automatic cs_hi();
    repeat (8) @(negedge iclk);
    cs = 1'b1;
    repeat (10) @(negedge iclk);
  endtask

  // Full frame; bytes at index >= cap_from are pushed to got_q.
  task automatic frame(input int n, input logic [7:0] b0, b1, b2, b3, input int cap_from);
    logic [7:0] tx[4];
    logic [7:0] rx;
    tx = '{b0, b1, b2, b3};
    cs_lo();
    for (int i = 0; i < n; i++) begin
      spi_bits(tx[i], 8, rx);
      if (i >= cap_from) got_q.push_back(rx);
    end
    cs_hi();
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_in = 12'h8A3; y_in = 12'h000; z_in = 12'h000;
    repeat (4) @(negedge iclk);
    n_chk++; if (miso !== 1'b0) $display("FAIL reset_miso got=%b exp=0", miso); else n_pass++;
    n_chk++; if (power_ctl !== 8'h00) $display("FAIL reset_power_ctl got=%h exp=00", power_ctl); else n_pass++;
    n_chk++; if (measure_on !== 1'b0) $display("FAIL reset_measure_on got=%b exp=0", measure_on); else n_pass++;
    n_chk++; if (reg_wr !== 1'b0) $display("FAIL reset_reg_wr got=%b exp=0", reg_wr); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge iclk);
  endtask

  task automatic test_read_id();
    int fd0;
    fd0 = fd_cnt;
    exp_q.push_back(8'hAD); exp_q.push_back(8'h1D);
    frame(4, 8'h0B, 8'h00, 8'h00, 8'h00, 2);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) $display("FAIL read_id got=%h exp=%h", g, e); else n_pass++;
    end
    n_chk++; if (fd_cnt - fd0 !== 1) $display("FAIL read_id_frame_done got=%0d exp=1", fd_cnt - fd0); else n_pass++;
  endtask

  task automatic test_gated_read(input logic [7:0] a, input logic [7:0] e0, e1, input string nm);
    exp_q.push_back(e0); exp_q.push_back(e1);
    frame(4, 8'h0B, a, 8'h00, 8'h00, 2);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) $display("FAIL %s got=%h exp=%h", nm, g, e); else n_pass++;
    end
  endtask

  task automatic test_write_power();
    int wr0, fd0;
    wr0 = wr_cnt; fd0 = fd_cnt;
    frame(3, 8'h0A, 8'h2D, 8'h02, 8'h00, 3);
    n_chk++; if (power_ctl !== 8'h02) $display("FAIL write_power_ctl got=%h exp=02", power_ctl); else n_pass++;
    n_chk++; if (measure_on !== 1'b1) $display("FAIL write_measure_on got=%b exp=1", measure_on); else n_pass++;
    n_chk++; if (wr_cnt - wr0 !== 1) $display("FAIL write_reg_wr got=%0d exp=1", wr_cnt - wr0); else n_pass++;
    n_chk++; if (fd_cnt - fd0 !== 1) $display("FAIL write_frame_done got=%0d exp=1", fd_cnt - fd0); else n_pass++;
  endtask

  task automatic test_shadow();
    logic [7:0] rx, e, g;
    exp_q.push_back(8'hA3); exp_q.push_back(8'hF8);
    cs_lo();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h0E, 8, rx);
    spi_bits(8'h00, 8, rx); got_q.push_back(rx);
    x_in = 12'h123;
    spi_bits(8'h00, 8, rx); got_q.push_back(rx);
    cs_hi();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) $display("FAIL shadow_same_frame got=%h exp=%h", g, e); else n_pass++;
    end
    test_gated_read(8'h0E, 8'h23, 8'h01, "shadow_next_frame");
  endtask

  task automatic test_axes();
    logic [7:0] e, g;
    y_in = 12'h7FF; z_in = 12'h800;
    exp_q.push_back(8'h12); exp_q.push_back(8'h7F); exp_q.push_back(8'h80);
    frame(4, 8'h0B, 8'h08, 8'h00, 8'h00, 2);
    frame(3, 8'h0B, 8'h0A, 8'h00, 8'h00, 2);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h07);
    frame(4, 8'h0B, 8'h10, 8'h00, 8'h00, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) $display("FAIL axes got=%h exp=%h", g, e); else n_pass++;
    end
  endtask

  task automatic test_partial_write();
    logic [7:0] rx;
    int wr0;
    wr0 = wr_cnt;
    cs_lo();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h01, 4, rx);
    cs_hi();
    n_chk++; if (power_ctl !== 8'h02) $display("FAIL partial_power_ctl got=%h exp=02", power_ctl); else n_pass++;
    n_chk++; if (wr_cnt - wr0 !== 0) $display("FAIL partial_reg_wr got=%0d exp=0", wr_cnt - wr0); else n_pass++;
  endtask

  task automatic test_ignore();
    logic [7:0] e, g;
    int wr0;
    wr0 = wr_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    frame(4, 8'h55, 8'h2D, 8'hFF, 8'hFF, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_chk++; if (g !== e) $display("FAIL ignore_miso got=%h exp=%h", g, e); else n_pass++;
    end
    n_chk++; if (power_ctl !== 8'h02) $display("FAIL ignore_power_ctl got=%h exp=02", power_ctl); else n_pass++;
    n_chk++; if (wr_cnt - wr0 !== 0) $display("FAIL ignore_reg_wr got=%0d exp=0", wr_cnt - wr0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int wr0;
    wr0 = wr_cnt;
    frame(4, 8'h0A, 8'h2C, 8'hAA, 8'h02, 4);
    n_chk++; if (wr_cnt - wr0 !== 2) $display("FAIL b2b_reg_wr got=%0d exp=2", wr_cnt - wr0); else n_pass++;
    n_chk++; if (power_ctl !== 8'h02) $display("FAIL b2b_power_ctl got=%h exp=02", power_ctl); else n_pass++;
    wr0 = wr_cnt;
    frame(3, 8'h0A, 8'h05, 8'h77, 8'h00, 3);
    n_chk++; if (wr_cnt - wr0 !== 1) $display("FAIL other_reg_wr got=%0d exp=1", wr_cnt - wr0); else n_pass++;
    n_chk++; if (power_ctl !== 8'h02) $display("FAIL other_power_ctl got=%h exp=02", power_ctl); else n_pass++;
    test_gated_read(8'h2D, 8'h02, 8'h00, "readback_power_ctl");
  endtask

  task automatic test_rst_mid();
    logic [7:0] rx;
    int wr0, fd0;
    wr0 = wr_cnt; fd0 = fd_cnt;
    cs_lo();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'hFF, 4, rx);
    rst = 1'b1;
    repeat (2) @(negedge iclk);
    n_chk++; if (miso !== 1'b0) $display("FAIL rst_mid_miso got=%b exp=0", miso); else n_pass++;
    n_chk++; if (power_ctl !== 8'h00) $display("FAIL rst_mid_power_ctl got=%h exp=00", power_ctl); else n_pass++;
    n_chk++; if (measure_on !== 1'b0) $display("FAIL rst_mid_measure_on got=%b exp=0", measure_on); else n_pass++;
    spi_bits(8'hFF, 4, rx);
    cs_hi();
    rst = 1'b0;
    repeat (4) @(negedge iclk);
    n_chk++; if (wr_cnt - wr0 !== 0) $display("FAIL rst_mid_reg_wr got=%0d exp=0", wr_cnt - wr0); else n_pass++;
    n_chk++; if (fd_cnt - fd0 !== 0) $display("FAIL rst_mid_frame_done got=%0d exp=0", fd_cnt - fd0); else n_pass++;
    test_gated_read(8'h00, 8'hAD, 8'h1D, "after_rst_read");
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_gated_read(8'h0E, 8'h00, 8'h00, "gated_x");
    test_write_power();
    test_gated_read(8'h0E, 8'hA3, 8'hF8, "x_lh");
    test_shadow();
    test_axes();
    test_partial_write();
    test_ignore();
    test_back_to_back();
    test_rst_mid();
    test_gated_read(8'hFF, 8'h00, 8'hAD, "addr_wrap");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adxl362_spi_slave.md
Name: adxl362_spi_slave

Overview:
- SPI mode-0 responder that emulates the ADXL362 register interface.
- Acts as the target for the team's ADXL362 SPI reader in closed-loop simulation and on-FPGA loopback tests, so the reader can be exercised without the physical sensor.
- Decodes write (0x0A) and read (0x0B) transactions with address auto-increment, and holds a small register map.
- Returns acceleration samples supplied by a stimulus source, shadowed so that each frame is coherent.

Parameters:
- DEVID_AD, 8'hAD, value returned at address 0x00.
- PARTID, 8'hF2, value returned at address 0x02.

Ports:
- iclk  input  1  system clock; must be at least 8x SCLK.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from the master; idle low (mode 0).
- cs  input  1  chip select, active low.
- mosi  input  1  serial data from the master, MSB first.
- miso  output  1  serial data to the master.
- x_in, y_in, z_in  input  12 each  signed acceleration samples.
- power_ctl  output  8  POWER_CTL register (address 0x2D).
- measure_on  output  1  high when power_ctl[1:0] == 2'b10.
- reg_wr  output  1  1-cycle pulse when a register write commits.
- frame_done  output  1  1-cycle pulse when cs is deasserted after an active frame.

Behaviour:
- Clock and reset:
  - Single clock domain (iclk); reset is asynchronous and active-high.
- Input synchronisation:
  - sclk, cs and mosi each pass through a 2-flop synchroniser.
  - Synchroniser reset values: sclk=0, cs=1, mosi=0.
  - Rise/fall detection uses the synchronised sclk; mosi is sampled on the detected rise.
- Reset values:
  - miso=0, power_ctl=0x00, measure_on=0, reg_wr=0, frame_done=0.
  - State IDLE; bit counter 0; address pointer 0; shadow registers 0.
- Shadowing:
  - On the synchronised cs falling edge, x_in, y_in and z_in are latched into shadow registers.
  - Every read in that frame returns the shadowed values.
- Register map (reads):
  - 0x00 DEVID_AD; 0x01 0x1D; 0x02 PARTID; 0x03 0x01.
  - 0x08/0x09/0x0A: x[11:4] / y[11:4] / z[11:4].
  - 0x0E X_L = x[7:0]; 0x0F X_H = {4{x[11]}, x[11:8]}. Y uses 0x10/0x11 and Z uses 0x12/0x13, with the same layout.
  - 0x2D power_ctl.
  - All other addresses read 0x00.
  - While measure_on=0, addresses 0x08-0x13 read 0x00.
- Writable registers:
  - Only 0x2D accepts writes; writes to any other address are discarded but still pulse reg_wr.
- State machine (bit counter counts detected rises within the current byte, 0..7, then wraps):
  - IDLE: on cs falling edge, go to CMD with the bit counter cleared.
  - CMD: shift 8 bits. 0x0A goes to ADDR as a write, 0x0B goes to ADDR as a read, any other value goes to IGNORE.
  - ADDR: shift 8 bits into the address pointer, then go to DATA.
    - For a read, tx_sh is loaded from reg[addr] on the 8th rise and the pointer increments.
  - DATA, write: each complete byte commits to reg[addr], pulses reg_wr for one cycle, then the pointer increments.
  - DATA, read: on every 8th rise, reload tx_sh from reg[addr] and increment the pointer.
    - Shift tx_sh left on each detected fall, except when the bit counter is 0 (the fall that follows a reload).
  - IGNORE: stays until cs rises; miso is held at 0.
  - The address pointer is 8 bits and wraps 0xFF -> 0x00.
- MISO:
  - miso = tx_sh[7] while cs is low and the state is DATA-read; otherwise 0.
- cs deasserted (synchronised rise) in any state:
  - Return to IDLE; any partial byte is discarded, with no commit and no reg_wr.
  - frame_done pulses once, unless the state was already IDLE.
- Simultaneous events: a byte completion and a cs rise in the same cycle → cs wins and the byte is discarded.
- Reset asserted mid-frame: immediate return to all reset values; the next frame needs a fresh cs falling edge.
- measure_on is combinational from power_ctl, so it updates in the same cycle as the write commit.

Test Plan:
- Reset, then frame 0x0B,0x00 followed by 2 dummy bytes → MISO bytes 0xAD, 0x1D; frame_done pulses once.
- Frame 0x0A,0x2D,0x02 → power_ctl=0x02, measure_on=1, exactly one reg_wr pulse.
- Before the POWER_CTL write, with x_in=12'h8A3, read 0x0B,0x0E for 2 bytes → 0x00, 0x00.
- After the POWER_CTL write, same read → 0xA3, 0xF8.
- Change x_in to 12'h123 between the X_L and X_H bytes → X_H still 0xF8 (shadowed); the next frame returns 0x23, 0x01.
- Each of the following leaves power_ctl unchanged and gives no reg_wr:
  - cs raised after 4 bits of the write data byte.
  - Command 0x55 (miso stays 0 for the whole frame).
  - rst asserted mid-frame, which additionally drives miso=0 and returns the state to IDLE.
- Read starting at 0xFF for 2 bytes → 0x00, 0xAD (address wrap).
